// File: rtl/uncached_bridge_pkg.sv
// uncached_bridge_pkg
// Shared types and constants for the uncached dbus-to-AXI bridge:
//   dbus_req_t / dbus_resp_t : requester-side handshake payloads
//   ub_entry_t               : one buffered request (FIFO entry)
//   ub_state_t               : AXI issue FSM states
//   AXI_BURST_INCR, AXI_LEN_SINGLE : tie-off values for single-beat bursts
package uncached_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  typedef struct packed {
    logic        req;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  write_en;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  write_en;
  } ub_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    W,
    B
  } ub_state_t;

  // Strip the handshake bit off a request to get the part worth storing.
  function automatic ub_entry_t to_entry(input dbus_req_t req);
    ub_entry_t e;
    e.is_write = req.is_write;
    e.size     = req.size;
    e.addr     = req.addr;
    e.data     = req.data;
    e.write_en = req.write_en;
    return e;
  endfunction

endpackage

// File: rtl/uncached_bridge_if.sv
// uncached_bridge_if
// Bundles the dbus request/response pair and the five single-beat AXI4
// channels that the bridge drives.
//   modport slave  : the bridge's view (responder on dbus, AXI master side)
//   modport master : the environment's view (requester on dbus, AXI slave)
// Only the AXI fields the bridge actually uses are carried; rresp, rlast
// and bresp are not inspected so they are left out.
interface uncached_bridge_if;
  import uncached_bridge_pkg::*;

  dbus_req_t   dreq;
  dbus_resp_t  dresp;

  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic [3:0]  awid;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic        bvalid;
  logic        bready;

  modport slave (
    input  dreq,
    output dresp,
    output araddr, arsize, arlen, arburst, arid, arvalid,
    input  arready,
    input  rdata, rvalid,
    output rready,
    output awaddr, awsize, awlen, awburst, awid, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport master (
    output dreq,
    input  dresp,
    input  araddr, arsize, arlen, arburst, arid, arvalid,
    output arready,
    output rdata, rvalid,
    input  rready,
    input  awaddr, awsize, awlen, awburst, awid, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );

endinterface

// File: rtl/uncached_bridge_fifo.sv
// ub_fifo
// Small in-order request FIFO with a combinational head.
//   clk, resetn      : clock, synchronous active-low reset
//   push, push_data  : write one entry (caller guarantees !full)
//   pop              : drop the head entry (caller guarantees !empty)
//   head             : current oldest entry
//   full, empty      : derived from the registered count only
// Storage is plain registers rather than block RAM: the issue FSM needs the
// head in the same cycle it decides what to launch, and DEPTH is tiny.
module ub_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  entry_t             mem_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [COUNT_W-1:0] count_reg;

  // Entry storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + COUNT_W'(1);
        2'b01:   count_reg <= count_reg - COUNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign full  = (count_reg == COUNT_W'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/uncached_bridge.sv
// uncached_bridge
// Responder end of the dbus handshake for uncached accesses. Each accepted
// request is queued in order and replayed as exactly one single-beat AXI4
// transaction; only one AXI transaction is ever outstanding, which keeps
// MMIO side effects in program order.
//   clk, resetn : clock, synchronous active-low reset
//   bus         : uncached_bridge_if.slave (dbus req/resp + AXI channels)
// Parameter DEPTH: request FIFO entries (power of two, >= 2).
module uncached_bridge
  import uncached_bridge_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  uncached_bridge_if.slave bus
);

  ub_entry_t   head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        addr_ok;
  logic        push;
  logic        pop;
  logic        launch_valid;
  logic        launch_write;

  ub_state_t   state_reg,     state_next;
  logic        arvalid_reg,   arvalid_next;
  logic        awvalid_reg,   awvalid_next;
  logic        wvalid_reg,    wvalid_next;
  logic        aw_done_reg,   aw_done_next;
  logic        w_done_reg,    w_done_next;
  logic        data_ok_reg,   data_ok_next;
  logic [31:0] resp_data_reg, resp_data_next;

  logic        aw_hs;
  logic        w_hs;

  // resetn is folded in so nothing is acknowledged while the FIFO is held
  // in reset.
  assign addr_ok = bus.dreq.req && !fifo_full && resetn;
  assign push    = addr_ok;

  ub_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (ub_entry_t)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (to_entry(bus.dreq)),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // An entry pushed into an empty FIFO is the head next cycle anyway, so
  // IDLE launches it straight away instead of waiting for the count.
  assign launch_valid = !fifo_empty || push;
  assign launch_write = fifo_empty ? bus.dreq.is_write : head.is_write;

  assign aw_hs = awvalid_reg && bus.awready;
  assign w_hs  = wvalid_reg && bus.wready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      arvalid_reg   <= 1'b0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      data_ok_reg   <= 1'b0;
      resp_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      arvalid_reg   <= arvalid_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
      data_ok_reg   <= data_ok_next;
      resp_data_reg <= resp_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    arvalid_next   = arvalid_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    aw_done_next   = aw_done_reg;
    w_done_next    = w_done_reg;
    data_ok_next   = 1'b0;
    resp_data_next = resp_data_reg;
    pop            = 1'b0;

    case (state_reg)
      IDLE: begin
        if (launch_valid) begin
          if (launch_write) begin
            state_next   = W;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
          end else begin
            state_next   = AR;
            arvalid_next = 1'b1;
          end
        end
      end

      AR: begin
        if (arvalid_reg && bus.arready) begin
          arvalid_next = 1'b0;
          state_next   = R;
        end
      end

      R: begin
        if (bus.rvalid) begin
          pop            = 1'b1;
          data_ok_next   = 1'b1;
          resp_data_next = bus.rdata;
          state_next     = IDLE;
        end
      end

      W: begin
        // AW and W complete independently; the done flags remember which
        // one has already gone, and both may land in the same cycle.
        if (aw_hs) begin
          awvalid_next = 1'b0;
        end
        if (w_hs) begin
          wvalid_next = 1'b0;
        end
        aw_done_next = aw_done_reg || aw_hs;
        w_done_next  = w_done_reg || w_hs;
        if (aw_done_next && w_done_next) begin
          state_next = B;
        end
      end

      B: begin
        if (bus.bvalid) begin
          pop            = 1'b1;
          data_ok_next   = 1'b1;
          resp_data_next = '0;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.dresp = '{addr_ok: addr_ok, data_ok: data_ok_reg, data: resp_data_reg};

  // The head cannot change while a transaction is in flight (pop only
  // happens on completion), so channel payloads come straight from it.
  assign bus.araddr  = head.addr;
  assign bus.arsize  = head.size;
  assign bus.arlen   = AXI_LEN_SINGLE;
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arid    = '0;
  assign bus.arvalid = arvalid_reg;

  assign bus.rready  = (state_reg == R);

  assign bus.awaddr  = head.addr;
  assign bus.awsize  = head.size;
  assign bus.awlen   = AXI_LEN_SINGLE;
  assign bus.awburst = AXI_BURST_INCR;
  assign bus.awid    = '0;
  assign bus.awvalid = awvalid_reg;

  assign bus.wdata   = head.data;
  assign bus.wstrb   = head.write_en;
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = wvalid_reg;

  assign bus.bready  = (state_reg == B);

endmodule
